// File: rtl/phys_reg_free_list_if.sv
// Rename-stage free-list bus: dispatch allocate, commit retire/release, flush,
// and the free-list status returned to dispatch.
interface phys_reg_free_list_if #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
);
  localparam int unsigned DEPTH  = NUM_PHYS - NUM_ARCH;
  localparam int unsigned PREG_W = $clog2(NUM_PHYS);
  localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;

  logic              alloc_req;
  logic [PREG_W-1:0] alloc_preg;
  logic              fl_empty;
  logic              retire_alloc;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              flush;
  logic [PTR_W-1:0]  free_count;
  logic              underflow_err;
  logic              overflow_err;

  modport master (
    output alloc_req, retire_alloc, free_valid, free_preg, flush,
    input  alloc_preg, fl_empty, free_count, underflow_err, overflow_err
  );

  modport slave (
    input  alloc_req, retire_alloc, free_valid, free_preg, flush,
    output alloc_preg, fl_empty, free_count, underflow_err, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular physical-register free list with speculative head, committed head
// and tail; flush rewinds the speculative head to the committed head.
module phys_reg_free_list #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  phys_reg_free_list_if.slave   fl
);
  localparam int unsigned DEPTH  = NUM_PHYS - NUM_ARCH;
  localparam int unsigned PREG_W = $clog2(NUM_PHYS);
  localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W  = PTR_W - 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  spec_head_q, spec_head_d;
  logic [PTR_W-1:0]  cmt_head_q, cmt_head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, cmt_caught_up;
  logic              do_alloc, do_retire, do_free;

  assign empty         = (spec_head_q == tail_q);
  assign full          = ((tail_q - cmt_head_q) == PTR_W'(DEPTH));
  assign cmt_caught_up = (cmt_head_q == spec_head_q);

  assign fl.alloc_preg    = mem_q[spec_head_q[IDX_W-1:0]];
  assign fl.fl_empty      = empty;
  assign fl.free_count    = tail_q - spec_head_q;
  assign fl.underflow_err = underflow_q;
  assign fl.overflow_err  = overflow_q;

  always_comb begin
    do_alloc  = fl.alloc_req && !empty && !fl.flush;
    do_retire = fl.retire_alloc && !cmt_caught_up;
    do_free   = fl.free_valid && !full;

    cmt_head_d  = cmt_head_q + PTR_W'(do_retire);
    // Flush rewinds to the committed head including this cycle's retire.
    spec_head_d = fl.flush ? cmt_head_d : spec_head_q + PTR_W'(do_alloc);
    tail_d      = tail_q + PTR_W'(do_free);

    underflow_d = underflow_q
                | (fl.alloc_req && empty && !fl.flush)
                | (fl.retire_alloc && cmt_caught_up);
    overflow_d  = overflow_q | (fl.free_valid && full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PREG_W'(NUM_ARCH + i);
      end
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= PTR_W'(DEPTH);
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_free) begin
        mem_q[tail_q[IDX_W-1:0]] <= fl.free_preg;
      end
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus randomized traffic
// against a queue model of committed-free registers and a speculative count.
module tb_phys_reg_free_list;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH)) bus ();

  phys_reg_free_list #(.NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (bus)
  );

  int checks = 0;
  int failures = 0;

  // q holds every register not yet consumed by a committed instruction, oldest
  // first; the first n_spec of them are speculatively handed out.
  int q[$];
  int n_spec;
  bit m_uf, m_of;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(NUM_ARCH + i);
    n_spec = 0;
    m_uf = 1'b0;
    m_of = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.alloc_req = 1'b0;
    bus.retire_alloc = 1'b0;
    bus.free_valid = 1'b0;
    bus.free_preg = '0;
    bus.flush = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input bit a, input bit r, input bit fv, input int p, input bit fl);
    bit was_empty, can_retire, was_full;
    bus.alloc_req = a;
    bus.retire_alloc = r;
    bus.free_valid = fv;
    bus.free_preg = 6'(p);
    bus.flush = fl;
    @(posedge clk);
    was_empty = (n_spec == q.size());
    can_retire = (n_spec > 0);
    was_full = (q.size() == DEPTH);
    if (a && was_empty && !fl) m_uf = 1'b1;
    if (r && !can_retire) m_uf = 1'b1;
    if (r && can_retire) begin
      void'(q.pop_front());
      n_spec--;
    end
    if (a && !was_empty && !fl) n_spec++;
    if (fv) begin
      if (was_full) m_of = 1'b1;
      else q.push_back(p);
    end
    if (fl) n_spec = 0;
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.free_count !== 6'd32) begin failures++; $display("FAIL reset_free_count: got %0d expected 32", bus.free_count); end
    checks++; if (bus.fl_empty !== 1'b0) begin failures++; $display("FAIL reset_empty: got %0b expected 0", bus.fl_empty); end
    checks++; if (bus.alloc_preg !== 6'd32) begin failures++; $display("FAIL reset_preg: got %0d expected 32", bus.alloc_preg); end
    checks++; if (bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0) begin failures++; $display("FAIL reset_errs: got uf=%0b of=%0b expected 0 0", bus.underflow_err, bus.overflow_err); end
  endtask

  task automatic test_drain();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.alloc_preg !== 6'(NUM_ARCH + i) || bus.fl_empty !== 1'b0) begin failures++; $display("FAIL drain_preg[%0d]: got %0d empty=%0b expected %0d empty=0", i, bus.alloc_preg, bus.fl_empty, NUM_ARCH + i); end
      step(1, 0, 0, 0, 0);
    end
    checks++; if (bus.fl_empty !== 1'b1 || bus.free_count !== 6'd0) begin failures++; $display("FAIL drain_empty: got empty=%0b count=%0d expected 1 0", bus.fl_empty, bus.free_count); end
  endtask

  task automatic test_empty_release();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    checks++; if (bus.underflow_err !== 1'b1) begin failures++; $display("FAIL empty_underflow: got %0b expected 1", bus.underflow_err); end
    checks++; if (bus.fl_empty !== 1'b1 || bus.free_count !== 6'd0) begin failures++; $display("FAIL empty_hold: got empty=%0b count=%0d expected 1 0", bus.fl_empty, bus.free_count); end
    step(0, 0, 1, 5, 0);
    checks++; if (bus.fl_empty !== 1'b0 || bus.alloc_preg !== 6'd5) begin failures++; $display("FAIL release_visible: got empty=%0b preg=%0d expected 0 5", bus.fl_empty, bus.alloc_preg); end
    checks++; if (bus.free_count !== 6'd1 || bus.overflow_err !== 1'b0) begin failures++; $display("FAIL release_count: got count=%0d of=%0b expected 1 0", bus.free_count, bus.overflow_err); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    for (int i = 0; i < 22; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) step(0, 1, 0, 0, 0);
    checks++; if (bus.free_count !== 6'd10) begin failures++; $display("FAIL same_pre_count: got %0d expected 10", bus.free_count); end
    step(1, 0, 1, 9, 0);
    checks++; if (bus.free_count !== 6'd10) begin failures++; $display("FAIL same_count: got %0d expected 10", bus.free_count); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.alloc_preg !== 6'(55 + i)) begin failures++; $display("FAIL same_order[%0d]: got %0d expected %0d", i, bus.alloc_preg, 55 + i); end
      step(1, 0, 0, 0, 0);
    end
    checks++; if (bus.alloc_preg !== 6'd9 || bus.free_count !== 6'd1) begin failures++; $display("FAIL same_released: got preg=%0d count=%0d expected 9 1", bus.alloc_preg, bus.free_count); end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    checks++; if (bus.free_count !== 6'd25) begin failures++; $display("FAIL flush_pre_count: got %0d expected 25", bus.free_count); end
    step(0, 0, 0, 0, 1);
    checks++; if (bus.free_count !== 6'd29 || bus.alloc_preg !== 6'd35) begin failures++; $display("FAIL flush_recover: got count=%0d preg=%0d expected 29 35", bus.free_count, bus.alloc_preg); end
  endtask

  task automatic test_flush_coincident();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 7, 1);
    checks++; if (bus.free_count !== 6'd30 || bus.alloc_preg !== 6'd35) begin failures++; $display("FAIL flushco_state: got count=%0d preg=%0d expected 30 35", bus.free_count, bus.alloc_preg); end
    checks++; if (bus.underflow_err !== 1'b0 || bus.overflow_err !== 1'b0) begin failures++; $display("FAIL flushco_errs: got uf=%0b of=%0b expected 0 0", bus.underflow_err, bus.overflow_err); end
    for (int i = 0; i < 29; i++) step(1, 0, 0, 0, 0);
    checks++; if (bus.alloc_preg !== 6'd7 || bus.free_count !== 6'd1) begin failures++; $display("FAIL flushco_release: got preg=%0d count=%0d expected 7 1", bus.alloc_preg, bus.free_count); end
  endtask

  task automatic test_random(input int cycles, input int free_pct);
    int exp_fc;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
           $urandom_range(0, 99) < free_pct, $urandom_range(0, NUM_PHYS - 1),
           $urandom_range(0, 19) == 0);
      exp_fc = q.size() - n_spec;
      checks++; if (bus.free_count !== 6'(exp_fc)) begin failures++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, bus.free_count, exp_fc); end
      checks++; if (bus.fl_empty !== (exp_fc == 0)) begin failures++; $display("FAIL rand_empty@%0d: got %0b expected %0b", c, bus.fl_empty, exp_fc == 0); end
      if (exp_fc != 0) begin
        checks++; if (bus.alloc_preg !== 6'(q[n_spec])) begin failures++; $display("FAIL rand_preg@%0d: got %0d expected %0d", c, bus.alloc_preg, q[n_spec]); end
      end
      checks++; if (bus.underflow_err !== m_uf || bus.overflow_err !== m_of) begin failures++; $display("FAIL rand_errs@%0d: got uf=%0b of=%0b expected %0b %0b", c, bus.underflow_err, bus.overflow_err, m_uf, m_of); end
    end
  endtask

  task automatic test_overflow_async_reset();
    apply_reset();
    step(0, 0, 1, 3, 0);
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow_err); end
    checks++; if (bus.free_count !== 6'd32 || bus.alloc_preg !== 6'd32) begin failures++; $display("FAIL ovf_suppress: got count=%0d preg=%0d expected 32 32", bus.free_count, bus.alloc_preg); end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    checks++; if (bus.alloc_preg !== 6'd37 || bus.free_count !== 6'd27) begin failures++; $display("FAIL ovf_pre_reset: got preg=%0d count=%0d expected 37 27", bus.alloc_preg, bus.free_count); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.alloc_preg !== 6'd32 || bus.free_count !== 6'd32 || bus.fl_empty !== 1'b0) begin failures++; $display("FAIL async_reset_state: got preg=%0d count=%0d empty=%0b expected 32 32 0", bus.alloc_preg, bus.free_count, bus.fl_empty); end
    checks++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin failures++; $display("FAIL async_reset_errs: got uf=%0b of=%0b expected 0 0", bus.underflow_err, bus.overflow_err); end
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_drain();
    test_empty_release();
    test_same_cycle();
    test_flush();
    test_flush_coincident();
    test_random(600, 40);
    test_random(400, 70);
    test_overflow_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
